// File: rtl/axil_boot_sequencer.sv
// Boot sequencer: copies a host-supplied program into RAM over AXI-Lite, then
// releases the CPU from reset and waits for its exit write or a run timeout.
module axil_boot_sequencer #(
  parameter int          ADDR_WIDTH    = 17,
  parameter int          RELEASE_DELAY = 16,
  parameter logic [31:0] TIMEOUT       = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic [ADDR_WIDTH-1:0] ext_awaddr,
  output logic                  ext_awvalid,
  input  logic                  ext_awready,
  output logic [31:0]           ext_wdata,
  output logic                  ext_wvalid,
  input  logic                  ext_wready,
  input  logic                  ext_bvalid,
  output logic                  ext_bready,
  output logic                  cpu_resetn,
  input  logic [31:0]           ctrl_awaddr,
  input  logic                  ctrl_awvalid,
  output logic                  ctrl_awready,
  input  logic [31:0]           ctrl_wdata,
  input  logic                  ctrl_wvalid,
  output logic                  ctrl_wready,
  output logic                  ctrl_bvalid,
  input  logic                  ctrl_bready,
  output logic                  done,
  output logic                  timed_out,
  output logic [31:0]           exit_code
);

  localparam int DW = $clog2(RELEASE_DELAY + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RESP    = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  last_q;
  logic                  aw_pend, w_pend;
  logic [DW-1:0]         dly_cnt;
  logic [31:0]           run_cnt;
  logic                  bvalid_q;
  logic                  done_q, timed_out_q;
  logic [31:0]           exit_q;

  logic load_accept, aw_hs, w_hs, ctrl_accept, exit_hit, timeout_hit;
  logic unused_ctrl_addr;

  // Only the low offset nibble selects the exit register; the base is don't-care.
  assign unused_ctrl_addr = ^ctrl_awaddr[31:4];

  assign load_accept = load_valid & load_ready;
  assign aw_hs       = ext_awvalid & ext_awready;
  assign w_hs        = ext_wvalid & ext_wready;
  assign ctrl_accept = (state == RUN) & ctrl_awvalid & ctrl_wvalid & ~bvalid_q;
  assign exit_hit    = ctrl_accept & (ctrl_awaddr[3:0] == 4'h0);
  // An exit write landing on the final budgeted cycle takes priority.
  assign timeout_hit = (state == RUN) & (TIMEOUT != 32'd0) &
                       (run_cnt == TIMEOUT - 32'd1) & ~exit_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid) state_next = WRITE;
      WRITE:   if ((!aw_pend || ext_awready) && (!w_pend || ext_wready))
                 state_next = RESP;
      RESP:    if (ext_bvalid) state_next = last_q ? RELEASE : IDLE;
      RELEASE: if (dly_cnt == '0) state_next = RUN;
      RUN:     if (exit_hit || timeout_hit) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the latched word payload carries no reset; its valid flags do, and
  // nothing downstream looks at the payload while they are low.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      addr_q <= load_addr;
      data_q <= load_data;
      last_q <= load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      dly_cnt     <= '0;
      run_cnt     <= '0;
      bvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      exit_q      <= '0;
    end else begin
      // Each channel drops on its own handshake and stays low until the next word.
      if (load_accept) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else begin
        if (aw_hs) aw_pend <= 1'b0;
        if (w_hs)  w_pend  <= 1'b0;
      end

      if (state == RESP && ext_bvalid)
        dly_cnt <= DW'(RELEASE_DELAY);
      else if (state == RELEASE && dly_cnt != '0)
        dly_cnt <= dly_cnt - DW'(1);

      if (state == RUN) run_cnt <= run_cnt + 32'd1;

      if (ctrl_accept)      bvalid_q <= 1'b1;
      else if (ctrl_bready) bvalid_q <= 1'b0;

      if (exit_hit) begin
        exit_q <= ctrl_wdata;
        done_q <= 1'b1;
      end
      if (timeout_hit) begin
        done_q      <= 1'b1;
        timed_out_q <= 1'b1;
      end
    end
  end

  // load_ready is qualified by resetn so it reads low for the whole reset.
  assign load_ready   = (state == IDLE) & resetn;
  assign ext_awaddr   = addr_q;
  assign ext_wdata    = data_q;
  assign ext_awvalid  = (state == WRITE) & aw_pend;
  assign ext_wvalid   = (state == WRITE) & w_pend;
  assign ext_bready   = (state == RESP);
  assign cpu_resetn   = (state == RUN) | (state == DONE);
  assign ctrl_awready = ctrl_accept;
  assign ctrl_wready  = ctrl_accept;
  assign ctrl_bvalid  = bvalid_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign exit_code    = exit_q;

endmodule

// File: tb/tb_axil_boot_sequencer.sv
// Directed bench for axil_boot_sequencer: program load, handshake ordering,
// reset release timing, CPU exit write, run timeout and mid-transfer reset.
module tb_axil_boot_sequencer;

  localparam int          AW  = 17;
  localparam int          DLY = 4;
  localparam logic [31:0] TMO = 32'd8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          load_valid, load_last;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW-1:0] ext_awaddr;
  logic          ext_awvalid, ext_awready;
  logic [31:0]   ext_wdata;
  logic          ext_wvalid, ext_wready;
  logic          ext_bvalid = 1'b0;
  logic          ext_bready;
  logic          cpu_resetn;
  logic [31:0]   ctrl_awaddr, ctrl_wdata;
  logic          ctrl_awvalid, ctrl_awready, ctrl_wvalid, ctrl_wready;
  logic          ctrl_bvalid, ctrl_bready;
  logic          done, timed_out;
  logic [31:0]   exit_code;

  axil_boot_sequencer #(
    .ADDR_WIDTH   (AW),
    .RELEASE_DELAY(DLY),
    .TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_last   (load_last),
    .ext_awaddr  (ext_awaddr),
    .ext_awvalid (ext_awvalid),
    .ext_awready (ext_awready),
    .ext_wdata   (ext_wdata),
    .ext_wvalid  (ext_wvalid),
    .ext_wready  (ext_wready),
    .ext_bvalid  (ext_bvalid),
    .ext_bready  (ext_bready),
    .cpu_resetn  (cpu_resetn),
    .ctrl_awaddr (ctrl_awaddr),
    .ctrl_awvalid(ctrl_awvalid),
    .ctrl_awready(ctrl_awready),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_wvalid (ctrl_wvalid),
    .ctrl_wready (ctrl_wready),
    .ctrl_bvalid (ctrl_bvalid),
    .ctrl_bready (ctrl_bready),
    .done        (done),
    .timed_out   (timed_out),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // RAM-side observer: records handshakes and the edge cpu_resetn rose on.
  logic [AW-1:0] aw_q[$];
  logic [31:0]   w_q[$];
  int   aw_n = 0, w_n = 0, b_n = 0, cyc = 0;
  int   last_b_edge = -1, rise_edge = -1;
  logic rst_prev = 1'b0;

  always @(posedge clk) begin
    if (ext_awvalid && ext_awready) begin aw_q.push_back(ext_awaddr); aw_n++; end
    if (ext_wvalid && ext_wready)   begin w_q.push_back(ext_wdata);   w_n++;  end
    if (ext_bvalid && ext_bready)   begin b_n++; last_b_edge = cyc; end
    if (cpu_resetn === 1'b1 && rst_prev !== 1'b1) rise_edge = cyc - 1;
    rst_prev = cpu_resetn;
    cyc++;
  end

  // RAM responds once both address and data of a write have been taken.
  always @(negedge clk)
    ext_bvalid = (((aw_n < w_n) ? aw_n : w_n) > b_n);

  task automatic clear_obs();
    aw_q.delete();
    w_q.delete();
    aw_n = 0; w_n = 0; b_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    load_valid = 1'b0; ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0; ctrl_bready = 1'b1;
    ext_awready = 1'b1; ext_wready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_obs();
    resetn = 1'b1;
  endtask

  // Offers one word and returns at the first negedge after it was accepted.
  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    @(negedge clk);
    load_addr = a; load_data = d; load_last = l; load_valid = 1'b1;
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (load_ready === 1'b1) ok = 1'b1;
      else begin @(negedge clk); #1; end
    end
    @(negedge clk);
    load_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL load_accept: word %h never accepted, want accept within 50 cycles", a); end
  endtask

  task automatic wait_b(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (b_n >= target) ok = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wait_bresp: got %0d responses, want %0d", b_n, target); end
  endtask

  // Returns on the negedge of the first RUN cycle.
  task automatic wait_run();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cpu_resetn === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wait_cpu_release: cpu_resetn=%b, want 1 within 100 cycles", cpu_resetn); end
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    @(negedge clk);
    #1;
    ctl = {load_ready, ext_awvalid, ext_wvalid, ext_bready, cpu_resetn,
           ctrl_awready, ctrl_wready, ctrl_bvalid, done, timed_out};
    n_cmp++;
    if (ctl !== 10'b0) begin n_fail++; $display("FAIL reset_controls: got %b want %b", ctl, 10'b0); end
    n_cmp++;
    if (exit_code !== 32'h0) begin n_fail++; $display("FAIL reset_exit_code: got %h want %h", exit_code, 32'h0); end
    do_reset();
    #1;
    n_cmp++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL idle_load_ready: got %b want 1", load_ready); end
    n_cmp++;
    if (cpu_resetn !== 1'b0) begin n_fail++; $display("FAIL idle_cpu_resetn: got %b want 0", cpu_resetn); end
  endtask

  task automatic test_load_and_exit();
    logic [AW-1:0] exp_a[3];
    logic [31:0]   exp_d[3];
    exp_a[0] = 17'h00000; exp_a[1] = 17'h00004; exp_a[2] = 17'h00008;
    exp_d[0] = 32'h1111_0001; exp_d[1] = 32'h2222_0002; exp_d[2] = 32'h3333_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load_word(exp_a[i], exp_d[i], (i == 2));
      wait_b(i + 1);
    end
    wait_run();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (aw_q.size() != 3 || aw_q[i] !== exp_a[i] || w_q.size() != 3 || w_q[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL load3_word%0d: got %0d aw/%0d w handshakes, want 3 each of addr %h data %h",
                 i, aw_q.size(), w_q.size(), exp_a[i], exp_d[i]);
      end
    end
    // RUN cycle 0: a lone address valid must not be accepted.
    ctrl_bready = 1'b1;
    ctrl_awaddr = 32'h1000_0004; ctrl_wdata = 32'h11; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b0;
    #1;
    n_cmp++;
    if (ctrl_awready !== 1'b0) begin n_fail++; $display("FAIL ctrl_single_channel: awready=%b want 0", ctrl_awready); end
    @(negedge clk);
    ctrl_wvalid = 1'b1;
    #1;
    n_cmp++;
    if ({ctrl_awready, ctrl_wready} !== 2'b11) begin n_fail++; $display("FAIL ctrl_accept_other: got %b want 11", {ctrl_awready, ctrl_wready}); end
    @(negedge clk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    #1;
    n_cmp++;
    if ({ctrl_bvalid, done} !== 2'b10) begin n_fail++; $display("FAIL ctrl_other_ack: bvalid,done=%b want 10", {ctrl_bvalid, done}); end
    @(negedge clk);
    ctrl_awaddr = 32'h1000_0000; ctrl_wdata = 32'h2A; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b1;
    #1;
    n_cmp++;
    if ({ctrl_bvalid, ctrl_awready, ctrl_wready} !== 3'b011) begin
      n_fail++; $display("FAIL ctrl_exit_accept: bvalid,awready,wready=%b want 011", {ctrl_bvalid, ctrl_awready, ctrl_wready});
    end
    @(negedge clk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0; ctrl_bready = 1'b0;
    #1;
    n_cmp++;
    if ({done, timed_out, ctrl_bvalid, cpu_resetn} !== 4'b1011 || exit_code !== 32'h2A) begin
      n_fail++; $display("FAIL exit_done: done,to,bvalid,cpu_rst=%b exit=%h want 1011 exit=0000002a",
                         {done, timed_out, ctrl_bvalid, cpu_resetn}, exit_code);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (ctrl_bvalid !== 1'b1) begin n_fail++; $display("FAIL done_bvalid_hold: got %b want 1", ctrl_bvalid); end
    ctrl_bready = 1'b1;
    @(negedge clk);
    ctrl_awaddr = 32'h1000_0000; ctrl_wdata = 32'h99; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b1;
    #1;
    n_cmp++;
    if ({ctrl_bvalid, ctrl_awready, load_ready} !== 3'b000) begin
      n_fail++; $display("FAIL done_accepts_nothing: bvalid,awready,load_ready=%b want 000", {ctrl_bvalid, ctrl_awready, load_ready});
    end
    @(negedge clk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    n_cmp++;
    if (exit_code !== 32'h2A || done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: exit=%h done=%b want 0000002a 1", exit_code, done); end
    n_cmp++;
    if (rise_edge - last_b_edge !== DLY + 1) begin
      n_fail++; $display("FAIL release_delay: cpu_resetn rose %0d cycles after last bresp, want %0d", rise_edge - last_b_edge, DLY + 1);
    end
  endtask

  // Runs to the negedge of RUN cycle 7, the last cycle before the budget expires.
  task automatic reach_run7();
    do_reset();
    load_word(17'h00040, 32'h0000_0013, 1'b1);
    wait_b(1);
    wait_run();
    for (int k = 1; k <= 7; k++) @(negedge clk);
  endtask

  task automatic test_timeout();
    reach_run7();
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL timeout_early: done=%b after 7 RUN cycles, want 0", done); end
    @(negedge clk);
    n_cmp++;
    if ({done, timed_out, cpu_resetn} !== 3'b111 || exit_code !== 32'h0) begin
      n_fail++; $display("FAIL timeout_fire: done,to,cpu_rst=%b exit=%h want 111 exit=00000000", {done, timed_out, cpu_resetn}, exit_code);
    end
  endtask

  task automatic test_exit_vs_timeout();
    reach_run7();
    ctrl_bready = 1'b1;
    ctrl_awaddr = 32'h1000_0000; ctrl_wdata = 32'h55; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b1;
    @(negedge clk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    n_cmp++;
    if ({done, timed_out} !== 2'b10 || exit_code !== 32'h55) begin
      n_fail++; $display("FAIL exit_wins_timeout: done,to=%b exit=%h want 10 exit=00000055", {done, timed_out}, exit_code);
    end
  endtask

  task automatic test_split_ready();
    do_reset();
    ext_awready = 1'b0; ext_wready = 1'b0;
    load_word(17'h00100, 32'hDEAD_BEEF, 1'b0);
    #1;
    n_cmp++;
    if ({ext_awvalid, ext_wvalid} !== 2'b11 || ext_awaddr !== 17'h00100) begin
      n_fail++; $display("FAIL split_start: aw,w valid=%b addr=%h want 11 addr=00100", {ext_awvalid, ext_wvalid}, ext_awaddr);
    end
    ext_awready = 1'b1;
    @(negedge clk);
    ext_awready = 1'b0;
    #1;
    n_cmp++;
    if ({ext_awvalid, ext_wvalid} !== 2'b01 || ext_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL split_aw_drop: aw,w valid=%b data=%h want 01 data=deadbeef", {ext_awvalid, ext_wvalid}, ext_wdata);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ext_awvalid, ext_wvalid, ext_bready} !== 3'b010) begin
      n_fail++; $display("FAIL split_w_held: aw,w valid,bready=%b want 010", {ext_awvalid, ext_wvalid, ext_bready});
    end
    ext_wready = 1'b1;
    @(negedge clk);
    ext_wready = 1'b0;
    #1;
    n_cmp++;
    if ({ext_awvalid, ext_wvalid, ext_bready} !== 3'b001) begin
      n_fail++; $display("FAIL split_resp: aw,w valid,bready=%b want 001", {ext_awvalid, ext_wvalid, ext_bready});
    end
    wait_b(1);
    n_cmp++;
    if (aw_q.size() != 1 || aw_q[0] !== 17'h00100 || w_q.size() != 1 || w_q[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL split_single_write: got %0d aw/%0d w handshakes, want 1 each of 00100/deadbeef", aw_q.size(), w_q.size());
    end
    n_cmp++;
    if ({load_ready, cpu_resetn} !== 2'b10) begin
      n_fail++; $display("FAIL split_back_idle: load_ready,cpu_rst=%b want 10", {load_ready, cpu_resetn});
    end
    ext_awready = 1'b1; ext_wready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [9:0] ctl;
    ext_awready = 1'b0; ext_wready = 1'b0;
    load_word(17'h00180, 32'hCAFE_0001, 1'b0);
    #1;
    n_cmp++;
    if (ext_wvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: wvalid=%b want 1", ext_wvalid); end
    resetn = 1'b0;
    @(negedge clk);
    #1;
    ctl = {load_ready, ext_awvalid, ext_wvalid, ext_bready, cpu_resetn,
           ctrl_awready, ctrl_wready, ctrl_bvalid, done, timed_out};
    n_cmp++;
    if (ctl !== 10'b0 || exit_code !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outputs: controls=%b exit=%h want 0000000000 exit=00000000", ctl, exit_code);
    end
    clear_obs();
    resetn = 1'b1; ext_awready = 1'b1; ext_wready = 1'b1;
    load_word(17'h00200, 32'h0BAD_F00D, 1'b1);
    wait_b(1);
    n_cmp++;
    if (aw_q.size() != 1 || aw_q[0] !== 17'h00200 || w_q.size() != 1 || w_q[0] !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL midrst_new_load: got %0d aw/%0d w handshakes, want 1 each of 00200/0badf00d", aw_q.size(), w_q.size());
    end
    wait_run();
  endtask

  initial begin
    resetn = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    ext_awready = 1'b1; ext_wready = 1'b1;
    ctrl_awaddr = '0; ctrl_wdata = '0; ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0; ctrl_bready = 1'b1;
    test_reset();
    test_load_and_exit();
    test_timeout();
    test_exit_vs_timeout();
    test_split_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
